contador_bcd_modulo: RTL
========================

Name: contador_bcd_modulo

Overview:
Synchronous two-digit BCD counter with a parametrised total modulus (60 for seconds/minutes, 24 for hours, 100 for a free-running two-digit count).
Supports up/down counting, count enable, validated parallel load, and a combinational carry/borrow for synchronous cascading.
Sits in the timekeeping chain: one instance per time field, each instance's carry driving the next instance's enable.

Parameters:
LIMIT, 60, total modulus; legal range 2..100; the count runs 0..LIMIT-1.
DIGIT_W, 4, width of each BCD digit; fixed at 4, exposed only for the package constant.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  count enable; sampled on the rising edge.
up_down  input  1  1 = count up, 0 = count down.
load  input  1  parallel-load request; takes priority over enable.
load_units  input  4  BCD units value to load.
load_tens  input  4  BCD tens value to load.
units  output  4  BCD units digit, registered.
tens  output  4  BCD tens digit, registered.
carry  output  1  combinational terminal-count/borrow strobe for cascading.
load_err  output  1  registered one-cycle flag: last load request was rejected.

Behaviour:
- reset low (asynchronous):
  - units=0, tens=0, load_err=0.
  - carry forced to 0 while reset is low.
- Value V = tens*10 + units. Both digits are always valid BCD (0..9) and V < LIMIT.
- Priority on each rising edge: load > enable > hold.
- Load, when load=1:
  - Accepted when load_units<=9, load_tens<=9 and load_tens*10+load_units < LIMIT.
  - On accept: digits take the load values and load_err<=0.
  - On reject: digits hold and load_err<=1 for exactly one cycle.
  - No count happens in a load cycle.
- Count up (enable=1, load=0, up_down=1):
  - Digits below the terminal: units 0..8 increments; units 9 goes to 0 with tens+1.
  - V = LIMIT-1 wraps to 00.
- Count down (enable=1, load=0, up_down=0):
  - units 1..9 decrements; units 0 goes to 9 with tens-1.
  - V = 0 wraps to LIMIT-1, i.e. tens=(LIMIT-1)/10, units=(LIMIT-1)%10.
- Hold (enable=0, load=0): digits unchanged, load_err<=0.
- carry = reset & enable & !load & (up_down ? V==LIMIT-1 : V==0).
  - Purely combinational, so the downstream stage advances on the same edge as this stage's wrap.
  - No ripple clocking.
- up_down changes take effect at the next edge; carry follows up_down combinationally.
- Reset mid-count clears immediately, independent of clock.
- Edge right after reset release: behaves normally from V=0.
  - A down-count from 0 with enable=1 shows carry=1 before that edge.
- LIMIT checks are elaboration-time constants; no runtime division.

Decomposition:
- Shared package contador_pkg:
  - DIGIT_W=4, BCD_MAX=9.
  - LIMIT_SEGUNDOS=60, LIMIT_MINUTOS=60, LIMIT_HORAS=24, LIMIT_LIVRE=100.
- Sub-module contador_digito: one BCD digit.
  - Ports: clock, reset, enable, up_down, load, load_val, top value, terminal flag out.
  - Instantiated twice.
- Parent logic: tens enable = units terminal, plus the LIMIT wrap override and load validation.

Test Plan:
- Reset: hold reset low and toggle clock -> units=0, tens=0, carry=0, load_err=0. Assert reset mid-count at V=37 -> 00 immediately, with no clock edge.
- Up wrap, LIMIT=60: load 58, enable=1, up -> 59 with carry=1 during the 59 cycle, then 00 with carry=0. Units 9->0 at V=19 -> tens increments to 20.
- Down wrap, LIMIT=24: load 01, enable=1, down -> 00 with carry=1, then 23. From 20 -> 19.
- Load validation, LIMIT=24: load_tens=2, load_units=5 -> value held, load_err=1 for one cycle. Load 1,0xA -> rejected. Load 2,3 -> accepted, load_err=0. load and enable together -> load wins, carry=0.
- Cascade: seconds (60) carry drives minutes (60) enable, starting from 59:59 with enable=1 -> next edge gives 00:00, minutes carry=1 only in the 59:59 cycle.
- Hold/direction: enable=0 for 5 cycles at V=42 -> stays 42, carry=0. Toggle up_down at V=0 with enable=1 -> carry goes 0/1 combinationally in the same cycle.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared constants, BCD digit type and helpers for the BCD timekeeping counters.
package contador_pkg;

  localparam int DIGIT_W = 32'd4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam int LIMIT_SEGUNDOS = 32'd60;
  localparam int LIMIT_MINUTOS  = 32'd60;
  localparam int LIMIT_HORAS    = 32'd24;
  localparam int LIMIT_LIVRE    = 32'd100;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_valid(input bcd_t d);
    return (d <= BCD_MAX);
  endfunction

  // Binary value of a two-digit BCD pair; large enough for out-of-range nibbles too.
  function automatic logic [7:0] bcd_pair_value(input bcd_t tens, input bcd_t units);
    return ({4'd0, tens} * 8'd10) + {4'd0, units};
  endfunction

endpackage

// File: rtl/contador_digito.sv
// One BCD digit: load has priority over a step, steps wrap between 0 and top_val.
module contador_digito
  import contador_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic up_down,
  input  logic load,
  input  bcd_t load_val,
  input  bcd_t top_val,
  output bcd_t value,
  output logic terminal
);

  bcd_t value_r;
  bcd_t next_s;

  // Next digit value: load, else step in the selected direction, else hold.
  always_comb begin
    next_s = value_r;
    if (load) begin
      next_s = load_val;
    end else if (enable) begin
      if (up_down) begin
        if (value_r == top_val) begin
          next_s = 4'd0;
        end else begin
          next_s = value_r + 4'd1;
        end
      end else begin
        if (value_r == 4'd0) begin
          next_s = top_val;
        end else begin
          next_s = value_r - 4'd1;
        end
      end
    end else begin
      next_s = value_r;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_r <= 4'd0;
    end else begin
      value_r <= next_s;
    end
  end

  // Terminal means the next step in this direction rolls the digit over.
  assign terminal = up_down ? (value_r == top_val) : (value_r == 4'd0);
  assign value    = value_r;

endmodule

// File: rtl/contador_bcd_modulo.sv
// Two-digit BCD counter with total modulus LIMIT, validated load and a
// combinational carry/borrow so cascaded stages advance on the same edge.
module contador_bcd_modulo #(
  parameter int LIMIT   = 60,
  parameter int DIGIT_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               up_down,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_units,
  input  logic [DIGIT_W-1:0] load_tens,
  output logic [DIGIT_W-1:0] units,
  output logic [DIGIT_W-1:0] tens,
  output logic               carry,
  output logic               load_err
);

  import contador_pkg::*;

  // Last legal value LIMIT-1 split into digits at elaboration time.
  localparam bcd_t       UNITS_LAST = 4'((LIMIT - 1) % 10);
  localparam bcd_t       TENS_LAST  = 4'((LIMIT - 1) / 10);
  localparam logic [7:0] LIMIT_V    = 8'(LIMIT);

  bcd_t units_s;
  bcd_t tens_s;
  bcd_t units_val_s;
  bcd_t tens_val_s;
  logic units_term_s;
  logic tens_term_s;
  logic load_ok_s;
  logic count_s;
  logic at_last_s;
  logic at_zero_s;
  logic wrap_s;
  logic digit_load_s;
  logic load_err_r;

  assign load_ok_s = bcd_valid(load_tens) & bcd_valid(load_units) &
                     (bcd_pair_value(load_tens, load_units) < LIMIT_V);

  assign count_s   = enable & ~load;
  assign at_last_s = (units_s == UNITS_LAST) & (tens_s == TENS_LAST);
  assign at_zero_s = (units_s == 4'd0) & (tens_s == 4'd0);

  // Whole-count wrap is done by forcing both digits through their load path,
  // since LIMIT-1 need not end in 9 (e.g. 23 for hours).
  assign wrap_s       = count_s & (up_down ? at_last_s : at_zero_s);
  assign digit_load_s = (load & load_ok_s) | wrap_s;

  // Values forced into the digits: external load, or the wrap target.
  always_comb begin
    units_val_s = 4'd0;
    tens_val_s  = 4'd0;
    if (load) begin
      units_val_s = load_units;
      tens_val_s  = load_tens;
    end else if (up_down) begin
      units_val_s = 4'd0;
      tens_val_s  = 4'd0;
    end else begin
      units_val_s = UNITS_LAST;
      tens_val_s  = TENS_LAST;
    end
  end

  contador_digito u_units (
    .clock    (clock),
    .reset    (reset),
    .enable   (count_s),
    .up_down  (up_down),
    .load     (digit_load_s),
    .load_val (units_val_s),
    .top_val  (BCD_MAX),
    .value    (units_s),
    .terminal (units_term_s)
  );

  contador_digito u_tens (
    .clock    (clock),
    .reset    (reset),
    .enable   (count_s & units_term_s),
    .up_down  (up_down),
    .load     (digit_load_s),
    .load_val (tens_val_s),
    .top_val  (BCD_MAX),
    .value    (tens_s),
    .terminal (tens_term_s)
  );

  // Rejected-load flag, valid for the single cycle after the bad request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_err_r <= 1'b0;
    end else if (load) begin
      load_err_r <= ~load_ok_s;
    end else begin
      load_err_r <= 1'b0;
    end
  end

  // The tens rollover is covered by the wrap override, so its terminal flag
  // only matters for cascading digits and is deliberately left unconnected here.
  logic unused_s;
  assign unused_s = tens_term_s;

  assign units    = units_s;
  assign tens     = tens_s;
  assign carry    = reset & wrap_s;
  assign load_err = load_err_r;

endmodule
